// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the synchronized rows,
// and debounces whole scans into a single key_code/key_valid event per physical press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_e;

    logic [3:0]         row_s1_q, row_s2_q;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         col_q, col_d;
    logic [3:0]         col_out_q, col_out_d;
    logic [1:0]         acc_cnt_q, acc_cnt_d;
    logic [3:0]         acc_code_q, acc_code_d;
    state_e             state_q, state_d;
    logic [3:0]         cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q, key_held_d;

    logic       sample, scan_end;
    logic [2:0] col_hits, total_hits;
    logic [3:0] col_code, scan_code;

    // NOTE: every always_comb output gets a default first so no path can leave a latch behind.
    always_comb begin
        dwell_d    = dwell_q;
        col_d      = col_q;
        col_out_d  = col_out_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;

        // Rows sit stable by the last dwell cycle, so that is the only sampling point.
        sample   = (dwell_q == DWELL_LAST);
        scan_end = sample && (col_q == 2'd3);

        col_hits = 3'd0;
        col_code = 4'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = {2'(r), col_q};
            end
        end
        total_hits = {1'b0, acc_cnt_q} + col_hits;
        scan_code  = (acc_cnt_q != 2'd0) ? acc_code_q : col_code;

        if (sample) begin
            dwell_d   = '0;
            col_d     = col_q + 2'd1;
            col_out_d = ~(4'b0001 << col_d);
            if (scan_end) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                // Saturate at 2: beyond "more than one key" the exact count is irrelevant.
                acc_cnt_d  = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
                acc_code_d = scan_code;
            end
        end else begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        if (scan_end) begin
            case (state_q)
                S_IDLE: begin
                    if (total_hits == 3'd1) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d  = scan_code;
                            key_valid_d = 1'b1;
                            state_d     = S_PRESSED;
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (total_hits == 3'd1) begin
                        if (scan_code == cand_q) begin
                            cnt_d = cnt_q + CNT_ONE;
                            if (cnt_d == CNT_TARGET) begin
                                key_code_d  = cand_q;
                                key_valid_d = 1'b1;
                                state_d     = S_PRESSED;
                            end
                        end else begin
                            cand_d = scan_code;
                            cnt_d  = CNT_ONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    // Any key activity keeps the press alive; rollover never re-fires.
                    if (total_hits == 3'd0) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (total_hits == 3'd0) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_TARGET) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_PRESSED;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        key_held_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: synchronizer flops reset to 1 (the idle pulled-up row level) so reset never looks like a press.
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            col_out_q   <= 4'b1110;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= S_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= row_in;
            row_s2_q    <= row_s1_q;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_out_q   <= col_out_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a key-matrix model drives row_in from col_out,
// expected key codes are queued at press time and matched against each key_valid pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 8;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int SCAN_CYC       = 4 * SCAN_DIV;
    localparam int ACCEPT_LAT     = DEBOUNCE_SCANS * SCAN_CYC;
    localparam logic [15:0] K9    = 16'h0200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          last_pulse_cyc = 0;
    int          t0;
    logic [3:0]  exp_q[$];

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: bit r*4+c closed pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
            check("held_with_valid", key_held, 1);
            if (exp_q.size() == 0) check("pulse_with_empty_sb", key_valid, 0);
            else                   check("key_code", key_code, exp_q.pop_front());
        end
    end

    task automatic wait_scans(input int n);
        repeat (n * SCAN_CYC) @(negedge clk);
    endtask

    // Returns at the first negedge of a scan (col_out just wrapped 0111 -> 1110).
    task automatic wait_boundary();
        logic [3:0] prev;
        bit found;
        prev  = col_out;
        found = 0;
        for (int i = 0; i < 2 * SCAN_CYC && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && col_out == 4'b1110) found = 1;
            prev = col_out;
        end
        check("boundary_found", found, 1);
    endtask

    task automatic wait_pulse(input int target, input int start, input string tag);
        int begun;
        begun = cyc;
        while (pulse_cnt < target && (cyc - begun) < 4 * ACCEPT_LAT) @(negedge clk);
        check({tag, "_seen"}, pulse_cnt, target);
        if (pulse_cnt >= target) check({tag, "_latency"}, last_pulse_cyc - start, ACCEPT_LAT);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, col_out, 4'b1110);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_held"}, key_held, 0);
        check({tag, "_code"}, key_code, 0);
    endtask

    initial begin
        // 1: reset state and idle column sequencing
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 2 * SCAN_CYC; i++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            check("idle_col", col_out, exp_col);
            @(negedge clk);
        end
        check("idle_valid", pulse_cnt, 0);
        check("idle_held", key_held, 0);

        // 3: bounce never reaches three identical scans
        wait_boundary();
        keys = K9; wait_scans(2);
        keys = '0; wait_scans(1);
        keys = K9; wait_scans(2);
        keys = '0; wait_scans(4);
        check("bounce_pulses", pulse_cnt, 0);
        check("bounce_code", key_code, 0);
        check("bounce_held", key_held, 0);

        // 2: clean press of row 2 / col 1, then held for 10 scans
        wait_boundary();
        t0 = cyc;
        exp_q.push_back(4'd9);
        keys = K9;
        wait_pulse(1, t0, "press9");
        wait_scans(10);
        check("hold_pulses", pulse_cnt, 1);
        check("hold_held", key_held, 1);
        check("hold_code", key_code, 9);

        // 4: release with a one-scan glitch, full release, then re-press
        wait_boundary();
        keys = '0; wait_scans(2);
        keys = K9; wait_scans(1);
        check("glitch_held", key_held, 1);
        check("glitch_pulses", pulse_cnt, 1);
        keys = '0;
        repeat (3 * SCAN_CYC - 1) @(negedge clk);
        check("release_before", key_held, 1);
        @(negedge clk);
        check("release_after", key_held, 0);
        wait_boundary();
        t0 = cyc;
        exp_q.push_back(4'd9);
        keys = K9;
        wait_pulse(2, t0, "repress");
        wait_boundary();
        keys = '0; wait_scans(4);
        check("repress_released", key_held, 0);

        // 5: ghosting from idle, then rollover while held
        wait_boundary();
        keys = 16'h8001; wait_scans(5);
        check("ghost_pulses", pulse_cnt, 2);
        check("ghost_held", key_held, 0);
        keys = '0; wait_scans(1);
        wait_boundary();
        t0 = cyc;
        exp_q.push_back(4'd6);
        keys = 16'h0040;
        wait_pulse(3, t0, "roll6");
        keys = 16'h0048; wait_scans(3);
        keys = 16'h0008; wait_scans(3);
        check("roll_pulses", pulse_cnt, 3);
        check("roll_code", key_code, 6);
        check("roll_held", key_held, 1);
        keys = '0; wait_scans(5);
        check("roll_released", key_held, 0);

        // 6: asynchronous reset mid-debounce and while pressed
        wait_boundary();
        keys = K9; wait_scans(2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_deb");
        repeat (3) @(negedge clk);
        exp_q.push_back(4'd9);
        rst_n = 1'b1;
        t0 = cyc;
        wait_pulse(4, t0, "after_rst_deb");
        wait_scans(1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_pressed");
        repeat (3) @(negedge clk);
        exp_q.push_back(4'd9);
        rst_n = 1'b1;
        t0 = cyc;
        wait_pulse(5, t0, "after_rst_pressed");
        keys = '0; wait_scans(5);
        check("final_held", key_held, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
